ps2_key_decoder: RTL and testbench

Consumes the byte stream from the PS/2 frame receiver (one scan-code byte per `code_valid` pulse) and interprets Set-2 make/break/extended sequences. It maintains a live 9-bit held-key vector for the game logic. It also queues discrete press/release events in a 4-entry show-ahead FIFO for the game controller, which drains it with a valid/ready handshake. The block sits directly downstream of the PS/2 shift-register receiver and upstream of the game controller.

---
 rtl/ps2_key_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Interprets the PS/2 Set-2 scan-code byte stream (make, F0 break and
//   E0 extended prefixes). It keeps a 9-bit held-key vector and queues
//   press/release events in a small show-ahead FIFO.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   code_byte     scan-code byte, sampled when code_valid=1
//   code_valid    one-cycle strobe per received byte
//   keys_pressed  held-key vector (1 = held)
//   evt_data      FIFO head {make, key_idx[3:0]}; 0 when empty
//   evt_valid     FIFO non-empty
//   evt_ready     consumer accepts the head when evt_valid=1
//   evt_overflow  sticky, set when an event is dropped on a full FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_byte,
  input  logic       code_valid,
  output logic [8:0] keys_pressed,
  output logic [4:0] evt_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  // {extended, code} for each key index; entry 0 is the rightmost element.
  localparam logic [8:0][8:0] KEY_TAB = {
    9'h029, 9'h174, 9'h172, 9'h16B, 9'h175,
    9'h023, 9'h01B, 9'h01C, 9'h01D
  };

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state_reg, state_next;
  logic [8:0]       keys_reg, keys_next;
  logic             ovf_reg, ovf_next;
  logic [4:0]       mem_reg [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;

  logic             is_ctrl;
  logic             dec_en, dec_ext, dec_brk;
  logic [8:0]       key_match;
  logic             key_hit;
  logic [3:0]       key_idx;
  logic             push, push_ok, pop, full;
  logic [4:0]       evt_new;

  // Link-control bytes (BAT, ACK, resend, echo, errors, pause prefix)
  // abandon any partially received prefix sequence.
  always_comb begin
    is_ctrl = 1'b0;
    case (code_byte)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

  // Prefix FSM: decides whether this byte is a key code and in what context.
  always_comb begin
    state_next = state_reg;
    dec_en     = 1'b0;
    dec_ext    = 1'b0;
    dec_brk    = 1'b0;
    if (code_valid) begin
      if (is_ctrl) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (code_byte == 8'hE0)      state_next = EXT;
            else if (code_byte == 8'hF0) state_next = BRK;
            else                         dec_en = 1'b1;
          end
          EXT: begin
            if (code_byte == 8'hF0)      state_next = EXT_BRK;
            else if (code_byte != 8'hE0) begin
              dec_en     = 1'b1;
              dec_ext    = 1'b1;
              state_next = IDLE;
            end
          end
          BRK: begin
            // F0 E0 ordering is tolerated as an extended break
            if (code_byte == 8'hE0)      state_next = EXT_BRK;
            else if (code_byte != 8'hF0) begin
              dec_en     = 1'b1;
              dec_brk    = 1'b1;
              state_next = IDLE;
            end
          end
          EXT_BRK: begin
            if (code_byte != 8'hE0 && code_byte != 8'hF0) begin
              dec_en     = 1'b1;
              dec_ext    = 1'b1;
              dec_brk    = 1'b1;
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_match
      assign key_match[gi] = (KEY_TAB[gi] == {dec_ext, code_byte});
    end
  endgenerate

  always_comb begin
    key_hit = |key_match;
    key_idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (key_match[i]) key_idx = 4'(i);
    end
  end

  // Only state changes of a key produce events; typematic repeats and
  // stray breaks are absorbed here.
  always_comb begin
    keys_next = keys_reg;
    push      = 1'b0;
    evt_new   = {~dec_brk, key_idx};
    if (dec_en && key_hit) begin
      if (!dec_brk && !keys_reg[key_idx]) begin
        keys_next[key_idx] = 1'b1;
        push               = 1'b1;
      end else if (dec_brk && keys_reg[key_idx]) begin
        keys_next[key_idx] = 1'b0;
        push               = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop        = (count_reg != '0) && evt_ready;
    full       = (count_reg == FULL_COUNT);
    push_ok    = push && (!full || pop);
    ovf_next   = ovf_reg | (push && full && !pop);
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      keys_reg   <= '0;
      ovf_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      keys_reg  <= keys_next;
      ovf_reg   <= ovf_next;
      count_reg <= count_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= evt_new;
  end

  assign keys_pressed = keys_reg;
  assign evt_valid    = (count_reg != '0);
  assign evt_data     = evt_valid ? mem_reg[rd_ptr_reg] : 5'd0;
  assign evt_overflow = ovf_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// randomized byte/handshake traffic, all checked against a behavioural model.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code_byte;
  logic       code_valid;
  logic [8:0] keys_pressed;
  logic [4:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_overflow;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_byte    (code_byte),
    .code_valid   (code_valid),
    .keys_pressed (keys_pressed),
    .evt_data     (evt_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: prefix flags, held-key set, event queue, sticky flag.
  bit         m_ext, m_brk, m_ovf;
  logic [8:0] m_keys;
  logic [4:0] m_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int key_lookup(input bit ext, input logic [7:0] b);
    case ({ext, b})
      9'h01D: return 0;
      9'h01C: return 1;
      9'h01B: return 2;
      9'h023: return 3;
      9'h175: return 4;
      9'h16B: return 5;
      9'h172: return 6;
      9'h174: return 7;
      9'h029: return 8;
      default: return -1;
    endcase
  endfunction

  // Drives one cycle of inputs, advances the model, then checks outputs.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    int k;
    bit pushm;
    logic [4:0] ev;
    code_valid = v;
    code_byte  = b;
    evt_ready  = rdy;
    pushm = 0;
    ev    = '0;
    if (v) begin
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1}) begin
        m_ext = 0;
        m_brk = 0;
      end else if (b == 8'hE0) begin
        m_ext = 1;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        k = key_lookup(m_ext, b);
        if (k >= 0) begin
          if (!m_brk && !m_keys[k]) begin
            m_keys[k] = 1'b1;
            pushm = 1;
            ev = {1'b1, 4'(k)};
          end else if (m_brk && m_keys[k]) begin
            m_keys[k] = 1'b0;
            pushm = 1;
            ev = {1'b0, 4'(k)};
          end
        end
        m_ext = 0;
        m_brk = 0;
      end
    end
    if (m_q.size() > 0 && rdy) begin
      $display("evt pop data=0x%02h make=%0d key=%0d", m_q[0], m_q[0][4], m_q[0][3:0]);
      void'(m_q.pop_front());
    end
    if (pushm) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    check_val("keys", 32'(keys_pressed), 32'(m_keys));
    check_val("valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check_val("overflow", 32'(evt_overflow), 32'(m_ovf));
    if (m_q.size() > 0) check_val("data", 32'(evt_data), 32'(m_q[0]));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code_byte  = 8'h00;
    evt_ready  = 1'b0;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_keys = '0;
    m_q.delete();
    #2;
    check_val("rst_keys", 32'(keys_pressed), 32'h0);
    check_val("rst_valid", 32'(evt_valid), 32'h0);
    check_val("rst_data", 32'(evt_data), 32'h0);
    check_val("rst_ovf", 32'(evt_overflow), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pool [16];
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74,
             8'h29, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'h00, 8'h45};

    do_reset();

    // Single press of A
    step(1, 8'h1C, 0);
    check_val("a_keys", 32'(keys_pressed), 32'h002);
    check_val("a_data", 32'(evt_data), 32'h11);
    check_val("a_valid", 32'(evt_valid), 32'h1);
    step(0, 8'h00, 1);
    step(1, 8'hF0, 1);
    step(1, 8'h1C, 1);
    step(0, 8'h00, 1);

    // Extended Down press and release with consumer ready
    step(1, 8'hE0, 1);
    step(1, 8'h72, 1);
    check_val("down_held", 32'(keys_pressed[6]), 32'h1);
    check_val("down_mk", 32'(evt_data), 32'h16);
    step(1, 8'hE0, 1);
    step(1, 8'hF0, 1);
    step(1, 8'h72, 1);
    check_val("down_brk", 32'(evt_data), 32'h06);
    step(0, 8'h00, 1);
    check_val("down_final", 32'(keys_pressed), 32'h0);

    // Typematic repeats collapse to one make
    step(1, 8'h1C, 0);
    step(1, 8'h1C, 0);
    step(1, 8'h1C, 0);
    step(1, 8'hF0, 0);
    step(1, 8'h1C, 0);
    check_val("typ_head", 32'(evt_data), 32'h11);
    step(0, 8'h00, 1);
    check_val("typ_next", 32'(evt_data), 32'h01);
    step(0, 8'h00, 1);
    check_val("typ_empty", 32'(evt_valid), 32'h0);

    // Unmapped keypad, control byte, stray break
    step(1, 8'h72, 0);
    step(1, 8'hAA, 0);
    step(1, 8'hF0, 0);
    step(1, 8'h29, 0);
    check_val("unm_keys", 32'(keys_pressed), 32'h0);
    check_val("unm_valid", 32'(evt_valid), 32'h0);

    // Overflow: five presses into a four-entry FIFO
    step(1, 8'h1D, 0);
    step(1, 8'h1C, 0);
    step(1, 8'h1B, 0);
    step(1, 8'h23, 0);
    step(1, 8'h29, 0);
    check_val("ovf_keys", 32'(keys_pressed), 32'h10F);
    check_val("ovf_flag", 32'(evt_overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check_val("ovf_drain", 32'(evt_data), 32'h10 + 32'(i));
      step(0, 8'h00, 1);
    end
    check_val("ovf_empty", 32'(evt_valid), 32'h0);

    // Reset in the middle of an extended prefix
    do_reset();
    step(1, 8'hE0, 0);
    do_reset();
    step(1, 8'h75, 0);
    check_val("abort_keys", 32'(keys_pressed), 32'h0);
    check_val("abort_valid", 32'(evt_valid), 32'h0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       v;
      logic [7:0] b;
      logic       r;
      logic [3:0] sel;
      v   = ($urandom_range(0, 99) < 65);
      sel = 4'($urandom_range(0, 15));
      b   = pool[sel];
      if (sel == 4'd15) b = 8'($urandom);
      r   = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 599) == 0) do_reset();
      step(v, b, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
